// File: rtl/sha512_stream_ctrl.sv
// ---------------------------------------------------------------------------
// sha512_stream_ctrl
//
// Streaming front end for sha512_core. Packs a big-endian 64-bit word stream
// into 1024-bit blocks and applies SHA-512 padding: the 0x80 marker byte,
// zero fill and a 128-bit big-endian bit length. It sequences the core one
// block at a time and returns the final digest over a valid/ready handshake.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   msg_data_i/valid_i     message word stream; byte 0 is [63:56]
//   msg_last_i, bytes_i    last word and its valid byte count (0 or >8 -> 8)
//   msg_empty_i            with msg_last_i: zero-length message, data ignored
//   msg_ready_o            word accepted when valid && ready
//   block_o                block to core, word 0 is [1023:960]
//   enable_hash_o          one-cycle start pulse to core
//   rst_hash_o             one-cycle pulse reloading the core IV
//   hold_i, idle_i         core busy / core idle
//   digest_i/valid_i       core digest and block-done strobe
//   digest_o/valid_o       registered final digest, held until digest_ready_i
//
// Optional build macro SHA512_CTRL_PERF_EN adds saturating counters
//   blocks_o (enable pulses issued) and msgs_o (digests delivered).
// ---------------------------------------------------------------------------
module sha512_stream_ctrl #(
  parameter int DataWidth   = 64,
  parameter int BlockWidth  = 1024,
  parameter int DigestWidth = 512,
  parameter int LenWidth    = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DataWidth-1:0]   msg_data_i,
  input  logic                   msg_valid_i,
  input  logic                   msg_last_i,
  input  logic [3:0]             msg_bytes_i,
  input  logic                   msg_empty_i,
  output logic                   msg_ready_o,
  output logic [BlockWidth-1:0]  block_o,
  output logic                   enable_hash_o,
  output logic                   rst_hash_o,
  input  logic                   hold_i,
  input  logic                   idle_i,
  input  logic [DigestWidth-1:0] digest_i,
  input  logic                   digest_valid_i,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o,
  input  logic                   digest_ready_i
`ifdef SHA512_CTRL_PERF_EN
  ,
  output logic [31:0]            blocks_o,
  output logic [31:0]            msgs_o
`endif
);

  localparam int Words = BlockWidth / DataWidth;
  localparam int IdxW  = $clog2(Words) + 1;
  localparam logic [DataWidth-1:0] PadWord = {8'h80, {(DataWidth-8){1'b0}}};

  typedef logic [0:Words-1][DataWidth-1:0] blk_t;

  // START is a separate state so the enable pulse is a clean Moore output
  // issued only after idle/hold were seen clear in HASH.
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_FILL, S_PAD, S_PADLEN, S_HASH, S_START, S_WAIT, S_OUT
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        pad_word_q, pad_word_d;  // word holding 0x80; Words = not yet placed
  logic [LenWidth-1:0]    len_q, len_d;
  blk_t                   blk_q, blk_d;
  logic                   final_q, final_d;
  logic                   padlen_q, padlen_d;      // a length-only block follows
  logic [DigestWidth-1:0] digest_q, digest_d;

  logic [3:0]             nbytes;
  logic [DataWidth-1:0]   last_word;
  logic [IdxW-1:0]        idx_nxt;
  logic [127:0]           len_field;

  assign nbytes    = (msg_bytes_i == 4'd0 || msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
  assign idx_nxt   = idx_q + 1'b1;
  assign len_field = 128'(len_q);

  // Keep the valid bytes of the last word, put 0x80 right after them, zero the rest.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    last_word = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(nbytes))       last_word[63-8*b -: 8] = msg_data_i[63-8*b -: 8];
      else if (b == int'(nbytes)) last_word[63-8*b -: 8] = 8'h80;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pad_word_d = pad_word_q;
    len_d      = len_q;
    blk_d      = blk_q;
    final_d    = final_q;
    padlen_d   = padlen_q;
    digest_d   = digest_q;

    unique case (state_q)
      S_IDLE: if (msg_valid_i) state_d = S_INIT;

      S_INIT: begin
        blk_d      = '0;
        idx_d      = '0;
        len_d      = '0;
        pad_word_d = '0;
        final_d    = 1'b0;
        padlen_d   = 1'b0;
        state_d    = S_FILL;
      end

      S_FILL: if (msg_valid_i) begin
        if (msg_last_i && msg_empty_i) begin
          blk_d[idx_q[IdxW-2:0]] = PadWord;
          pad_word_d = idx_q;
          state_d    = S_PAD;
        end else if (msg_last_i) begin
          blk_d[idx_q[IdxW-2:0]] = last_word;
          len_d = len_q + (LenWidth'(nbytes) << 3);
          idx_d = idx_nxt;
          if (nbytes == 4'd8) begin
            // Marker spills into the next word, possibly past this block.
            pad_word_d = idx_nxt;
            if (idx_nxt != IdxW'(Words)) blk_d[idx_nxt[IdxW-2:0]] = PadWord;
          end else begin
            pad_word_d = idx_q;
          end
          state_d = S_PAD;
        end else begin
          blk_d[idx_q[IdxW-2:0]] = msg_data_i;
          len_d = len_q + LenWidth'(DataWidth);
          idx_d = idx_nxt;
          if (idx_nxt == IdxW'(Words)) begin
            final_d = 1'b0;
            state_d = S_HASH;
          end
        end
      end

      S_PAD: begin
        if (pad_word_q <= IdxW'(Words - 3)) begin
          blk_d[Words-2] = len_field[127:64];
          blk_d[Words-1] = len_field[63:0];
          final_d        = 1'b1;
        end else begin
          final_d  = 1'b0;
          padlen_d = 1'b1;
        end
        state_d = S_HASH;
      end

      S_PADLEN: begin
        blk_d = '0;
        if (pad_word_q == IdxW'(Words)) blk_d[0] = PadWord;
        blk_d[Words-2] = len_field[127:64];
        blk_d[Words-1] = len_field[63:0];
        final_d        = 1'b1;
        padlen_d       = 1'b0;
        state_d        = S_HASH;
      end

      S_HASH: if (idle_i && !hold_i) state_d = S_START;

      S_START: state_d = S_WAIT;

      S_WAIT: if (digest_valid_i) begin
        if (final_q) begin
          digest_d = digest_i;
          state_d  = S_OUT;
        end else begin
          blk_d   = '0;
          idx_d   = '0;
          state_d = padlen_q ? S_PADLEN : S_FILL;
        end
      end

      S_OUT: if (digest_ready_i) state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pad_word_q <= '0;
      len_q      <= '0;
      // NOTE: the block buffer is wide but it drives block_o directly, which
      // must read zero in reset, so it is a reset register, not a RAM.
      blk_q      <= '0;
      final_q    <= 1'b0;
      padlen_q   <= 1'b0;
      digest_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q    <= state_d;
      idx_q      <= idx_d;
      pad_word_q <= pad_word_d;
      len_q      <= len_d;
      blk_q      <= blk_d;
      final_q    <= final_d;
      padlen_q   <= padlen_d;
      digest_q   <= digest_d;
    end
  end

  always_comb begin
    msg_ready_o    = (state_q == S_FILL);
    rst_hash_o     = (state_q == S_INIT);
    enable_hash_o  = (state_q == S_START);
    digest_valid_o = (state_q == S_OUT);
    block_o        = blk_q;
    digest_o       = digest_q;
  end

`ifdef SHA512_CTRL_PERF_EN
  logic [31:0] blocks_q, msgs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blocks_q <= '0;
      msgs_q   <= '0;
    end else begin
      if (enable_hash_o && blocks_q != '1)                   blocks_q <= blocks_q + 1'b1;
      if (digest_valid_o && digest_ready_i && msgs_q != '1) msgs_q   <= msgs_q + 1'b1;
    end
  end

  assign blocks_o = blocks_q;
  assign msgs_o   = msgs_q;
`endif

endmodule
